// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue buffer.
// Holds the RV32I opcode/funct constants used by the decoder and the
// decoded request record stored in the issue buffer.
package shift_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_SRA     = 7'b0100000;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
    logic        illegal;
  } shift_req_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational RV32I shift decoder.
// Ports:
//   instr    in  32  instruction word
//   rs1_val  in  32  source-1 value (always the data to shift)
//   rs2_val  in  32  source-2 value (shift amount source for OP)
//   req      out     decoded request; illegal words decode to a benign
//                    left shift by 0 with the illegal flag set
module shift_decode
  import shift_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output shift_req_t  req
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_op_imm;
  logic       f3_ok;
  logic       f7_ok;
  logic       legal;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign f3_ok     = (funct3 == F3_SLL) || (funct3 == F3_SR);
  // The SRA/SRAI encoding is only meaningful for right shifts.
  assign f7_ok     = (funct7 == F7_ZERO) ||
                     ((funct7 == F7_SRA) && (funct3 == F3_SR));
  assign legal     = (is_op || is_op_imm) && f3_ok && f7_ok;

  always_comb begin
    req         = '0;
    req.data    = rs1_val;
    req.rd      = instr[11:7];
    req.illegal = ~legal;
    if (legal) begin
      req.sa    = is_op ? rs2_val[4:0] : instr[24:20];
      req.right = (funct3 == F3_SR);
      req.arith = (funct3 == F3_SR) && instr[30];
    end
  end

endmodule

// File: rtl/shift_issue.sv
// Issue buffer for decoded shift requests.
// Decodes each accepted instruction and queues it in a DEPTH-entry FIFO
// feeding the shifter stage. Outputs come from storage only, so an entry
// is visible no earlier than the cycle after it was accepted.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous discard of all entries (wins over push/pop)
//   in_valid/in_ready     request handshake; in_ready is registered
//   instr/rs1_val/rs2_val instruction and operands
//   out_valid/out_ready   head handshake toward the shifter
//   out_*                 head entry fields, zero whenever out_valid=0
module shift_issue
  import shift_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_sa,
  output logic        out_right,
  output logic        out_arith,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  shift_req_t      dec_req;
  shift_req_t      mem [DEPTH];
  shift_req_t      head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            push;
  logic            pop;

  shift_decode u_decode (
    .instr   (instr),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .req     (dec_req)
  );

  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_valid = (count != '0);

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // in_ready tracks the next count so it is a pure flop output; a pop
  // while full therefore frees a slot only from the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt < DEPTH_C);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: it is only observed through out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_req;
  end

  // Gating on out_valid (count, async reset) zeroes the outputs
  // immediately on reset and whenever the buffer is empty.
  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_data    = head.data;
  assign out_sa      = head.sa;
  assign out_right   = head.right;
  assign out_arith   = head.arith;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_sa;
  logic        out_right;
  logic        out_arith;
  logic [4:0]  out_rd;
  logic        out_illegal;

  shift_issue #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sa(out_sa), .out_right(out_right),
    .out_arith(out_arith), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    shift_req_t  exp;
  } vec_t;

  vec_t        vecs [11];
  shift_req_t  sbq [$];
  shift_req_t  cur_exp;
  int          checks = 0;
  int          errors = 0;

  function automatic shift_req_t mk(input logic [31:0] d, input logic [4:0] sa,
                                    input logic r, input logic a,
                                    input logic [4:0] rd, input logic ill);
    shift_req_t t;
    t.data = d; t.sa = sa; t.right = r; t.arith = a; t.rd = rd; t.illegal = ill;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic shift_req_t outs();
    return mk(out_data, out_sa, out_right, out_arith, out_rd, out_illegal);
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    instr    = v.instr;
    rs1_val  = v.rs1;
    rs2_val  = v.rs2;
    cur_exp  = v.exp;
  endtask

  // One clock: score the pop/push that this edge performs, then advance.
  task automatic cycle();
    shift_req_t e;
    bit do_push, do_pop;
    do_push = in_valid && in_ready && !flush;
    do_pop  = out_valid && out_ready && !flush;
    if (do_pop) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got %0h expected nothing", outs());
      end else begin
        e = sbq.pop_front();
        chk("pop_entry", 64'(outs()), 64'(e));
      end
    end
    if (do_push) sbq.push_back(cur_exp);
    @(posedge clk); #1;
    if (flush) sbq.delete();
  endtask

  initial begin
    vecs[0]  = '{32'h40435293, 32'h80000010, 32'h0,        mk(32'h80000010, 5'd4,  1, 1, 5'd5,  0)}; // srai x5,x6,4
    vecs[1]  = '{32'h003110B3, 32'hDEADBEEF, 32'h00000123, mk(32'hDEADBEEF, 5'd3,  0, 0, 5'd1,  0)}; // sll
    vecs[2]  = '{32'h40511393, 32'h12345678, 32'h0,        mk(32'h12345678, 5'd0,  0, 0, 5'd7,  1)}; // slli f7=0100000
    vecs[3]  = '{32'h00C5D533, 32'hF0000000, 32'hFFFFFFFF, mk(32'hF0000000, 5'd31, 1, 0, 5'd10, 0)}; // srl
    vecs[4]  = '{32'h40C5D533, 32'h00000001, 32'h00000020, mk(32'h00000001, 5'd0,  1, 1, 5'd10, 0)}; // sra
    vecs[5]  = '{32'h01F21193, 32'h00000003, 32'hFFFFFFFF, mk(32'h00000003, 5'd31, 0, 0, 5'd3,  0)}; // slli 31
    vecs[6]  = '{32'h0010DF93, 32'hAAAA5555, 32'h0000001F, mk(32'hAAAA5555, 5'd1,  1, 0, 5'd31, 0)}; // srli x31
    vecs[7]  = '{32'h003100B3, 32'h11111111, 32'h00000004, mk(32'h11111111, 5'd0,  0, 0, 5'd1,  1)}; // add
    vecs[8]  = '{32'h023110B3, 32'h22222222, 32'h00000004, mk(32'h22222222, 5'd0,  0, 0, 5'd1,  1)}; // mulh
    vecs[9]  = '{32'h00111083, 32'h33333333, 32'h00000004, mk(32'h33333333, 5'd0,  0, 0, 5'd1,  1)}; // lh
    vecs[10] = '{32'h42435293, 32'h44444444, 32'h0,        mk(32'h44444444, 5'd0,  0, 0, 5'd5,  1)}; // srai f7=0100001

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    #11 rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_zero", 64'(outs()), 64'd0);

    // Table: one push per cycle, popped the cycle after
    out_ready = 1'b1;
    drive(vecs[0]);
    chk("no_comb_path", 64'(out_valid), 64'd0);
    cycle();
    chk("srai_next_cycle", 64'(outs()), 64'(vecs[0].exp));
    for (int i = 1; i < 11; i++) begin
      drive(vecs[i]);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("table_drained", 64'(out_valid), 64'd0);

    // Fill with out_ready low, then a single pop
    out_ready = 1'b0;
    drive(vecs[0]); cycle();
    drive(vecs[1]); cycle();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(vecs[3]);
    cycle();
    chk("full_hold_head", 64'(outs()), 64'(vecs[0].exp));
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("pop_cycle_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("after_pop_in_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("fill_drained", 64'(out_valid), 64'd0);

    // Steady push+pop at count=1 for 10 cycles
    drive(vecs[5]); cycle();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[(i * 3) % 11]);
      cycle();
      chk("stream_count1", 64'({out_valid, in_ready}), 64'b11);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Flush while full with a same-cycle offer
    out_ready = 1'b0;
    drive(vecs[6]); cycle();
    drive(vecs[4]); cycle();
    flush = 1'b1;
    drive(vecs[1]);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full", 64'({out_valid, in_ready}), 64'b01);
    chk("flush_out_zero", 64'(outs()), 64'd0);

    // Flush at count=1 beats a real push and pop
    drive(vecs[2]); cycle();
    out_ready = 1'b1; flush = 1'b1;
    drive(vecs[3]);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_push_pop", 64'({out_valid, in_ready}), 64'b01);
    // Pointers restart cleanly after flush
    drive(vecs[6]); cycle();
    in_valid = 1'b0; cycle();

    // Async reset with an entry at the head
    out_ready = 1'b0;
    drive(vecs[0]); cycle();
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", 64'({out_valid, in_ready}), 64'd0);
    chk("async_reset_data", 64'(outs()), 64'd0);
    sbq.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", 64'({out_valid, in_ready}), 64'b01);
    out_ready = 1'b1;
    drive(vecs[4]); cycle();
    in_valid = 1'b0; cycle();

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameter: DEPTH, default 2, number of buffered decoded shift requests; power of two, at least 2.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  instruction/operands offered.
REQ-006 in_ready  output  1  buffer can accept this cycle.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 rs1_val  input  32  source-1 register value.
REQ-009 rs2_val  input  32  source-2 register value.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_ready  input  1  shifter stage consumes head.
REQ-012 out_data  output  32  value to shift.
REQ-013 out_sa  output  5  shift amount.
REQ-014 out_right  output  1  shift right when 1, left when 0.
REQ-015 out_arith  output  1  arithmetic right shift when 1.
REQ-016 out_rd  output  5  destination register, instr[11:7].
REQ-017 out_illegal  output  1  instruction is not a legal RV32I shift.

Function
REQ-018 Decode SHALL recognise OP (opcode 0110011) and OP-IMM (0010011) with funct3 001 or 101.
REQ-019 Legal shift SHALL require instr[31:25] = 0000000, or 0100000 only when funct3 = 101.
REQ-020 funct3 001 SHALL decode to right=0, arith=0.
REQ-021 funct3 101 SHALL decode to right=1, with arith = instr[30].
REQ-022 Shift amount SHALL be rs2_val[4:0] for OP and instr[24:20] for OP-IMM.
REQ-023 data SHALL always be rs1_val.
REQ-024 Illegal instructions SHALL still be accepted, with illegal=1, sa=0, right=0, arith=0, data=rs1_val.
REQ-025 A push occurs on in_valid & in_ready; a pop occurs on out_valid & out_ready.
REQ-026 Entries SHALL leave in acceptance order (FIFO).
REQ-027 An entry accepted in cycle N SHALL appear at the outputs in cycle N+1 at the earliest; there is no combinational in-to-out path.
REQ-028 in_ready SHALL be registered and equal to (count < DEPTH); it does not depend on out_ready.
REQ-029 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-030 When count = DEPTH, a pop SHALL raise in_ready on the next cycle only.
REQ-031 Pointers SHALL wrap modulo DEPTH.
REQ-032 out_valid = 0 SHALL hold all out_* data outputs at 0.
REQ-033 The head entry's outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-034 flush SHALL empty the buffer in one cycle and take priority over a same-cycle push or pop; the flushed-cycle input is discarded.

Reset
REQ-035 rst_n low SHALL immediately force out_valid=0, all out_* data outputs 0, count=0, and both pointers 0.
REQ-036 in_ready SHALL be 0 while rst_n is low and 1 from the first clk edge after release.
REQ-037 Reset mid-operation SHALL discard all entries with no partial output.

Structure
REQ-038 Package shift_pkg SHALL hold the opcode constants OPC_OP and OPC_OP_IMM.
REQ-039 shift_pkg SHALL hold the constants F3_SLL, F3_SR, F7_ZERO and F7_SRA.
REQ-040 shift_pkg SHALL hold the struct shift_req_t {data, sa, right, arith, rd, illegal}.
REQ-041 Decode SHALL be the combinational sub-module shift_decode; shift_issue holds only storage, pointers and handshake.

Verification
REQ-042 SRAI x5,x6,4 (instr 0x40435293) with rs1=0x80000010 -> next cycle: out_data=0x80000010, sa=4, right=1, arith=1, rd=5, illegal=0.
REQ-043 SLL with rs2_val=0x00000123 -> sa=0x03 (upper bits ignored), right=0, arith=0.
REQ-044 SLLI with instr[31:25]=0100000 -> illegal=1, sa=0, right=0, arith=0.
REQ-045 Fill with out_ready=0 (DEPTH=2) -> in_ready=0 after two pushes; then one pop -> in_ready=1 the next cycle; FIFO order is preserved.
REQ-046 Push and pop every cycle for 10 cycles at count=1 -> count stays 1, and outputs match inputs delayed by one cycle.
REQ-047 Flush coinciding with push while count=2 -> next cycle: out_valid=0, count=0, in_ready=1.
REQ-048 rst_n low with out_valid=1 -> out_valid=0 asynchronously, before the next clk edge.
